// File: rtl/weight_readback_sequencer_if.sv
// Host/array-side signal bundle for the weight readback sequencer.
// The master side is the sequencer; the slave side is the array/host environment.
interface weight_readback_sequencer_if #(
  parameter int N_R = 81,
  parameter int FXP = 6,
  parameter int N_C = 32
);
  localparam int AW = $clog2(N_R * FXP);
  localparam int RW = $clog2(N_R);

  logic                 rd_start;
  logic                 rd_abort;
  logic [RW-1:0]        rd_row_first;
  logic [RW-1:0]        rd_row_last;
  logic                 compute_busy;
  logic [N_C-1:0]       COL_BITS;
  logic                 out_ready;
  logic                 read_en;
  logic [AW-1:0]        READ_ADDR;
  logic                 out_valid;
  logic [RW-1:0]        out_row;
  logic [N_C*FXP-1:0]   out_weights;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    input  rd_start, rd_abort, rd_row_first, rd_row_last, compute_busy,
           COL_BITS, out_ready,
    output read_en, READ_ADDR, out_valid, out_row, out_weights, busy, done, err
  );

  modport slave (
    output rd_start, rd_abort, rd_row_first, rd_row_last, compute_busy,
           COL_BITS, out_ready,
    input  read_en, READ_ADDR, out_valid, out_row, out_weights, busy, done, err
  );
endinterface

// File: rtl/weight_readback_sequencer.sv
// Reads each row's FXP bit-planes from the weight array one address at a time
// and streams the assembled per-column weights as one valid/ready beat per row.
//
// state   | meaning
// IDLE    | waiting for rd_start; invalid range pulses done+err
// ISSUE   | read_en asserted unless compute_busy stalls
// WAIT    | counting sense latency, captures COL_BITS on terminal count
// OUT     | assembled row held on out_valid until out_ready
// DONE    | one-cycle done pulse
module weight_readback_sequencer #(
  parameter int N_R      = 81,
  parameter int FXP      = 6,
  parameter int N_C      = 32,
  parameter int READ_LAT = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  weight_readback_sequencer_if.master bus
);
  localparam int AW = $clog2(N_R * FXP);
  localparam int RW = $clog2(N_R);
  localparam int BW = (FXP > 1) ? $clog2(FXP) : 1;
  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [RW-1:0] LAST_ROW = RW'(N_R - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(FXP - 1);
  localparam logic [AW-1:0] FXP_A    = AW'(FXP);
  localparam logic [CW-1:0] CNT_LOAD = CW'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [RW-1:0]        r_row;
  logic [RW-1:0]        r_last;
  logic [BW-1:0]        r_bit;
  logic [CW-1:0]        r_cnt;
  logic [AW-1:0]        r_addr;
  logic [N_C*FXP-1:0]   r_buf;
  logic                 r_out_valid;
  logic                 r_done;
  logic                 r_err;

  logic w_range_ok;

  assign w_range_ok = (bus.rd_row_first <= bus.rd_row_last) &&
                      (bus.rd_row_last <= LAST_ROW);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_last      <= '0;
      r_bit       <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_buf       <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (bus.rd_abort) begin
        r_state     <= S_IDLE;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.rd_start) begin
              if (w_range_ok) begin
                r_row   <= bus.rd_row_first;
                r_last  <= bus.rd_row_last;
                r_bit   <= '0;
                r_addr  <= AW'(bus.rd_row_first) * FXP_A;
                r_state <= S_ISSUE;
              end else begin
                r_done <= 1'b1;
                r_err  <= 1'b1;
              end
            end
          end
          S_ISSUE: begin
            if (!bus.compute_busy) begin
              r_cnt   <= CNT_LOAD;
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end else begin
              for (int c = 0; c < N_C; c++) begin
                for (int b = 0; b < FXP; b++) begin
                  if (r_bit == BW'(b)) r_buf[c*FXP + b] <= bus.COL_BITS[c];
                end
              end
              // Planes of consecutive rows are contiguous, so the address just steps.
              if (r_bit != BIT_MAX) begin
                r_bit   <= r_bit + 1'b1;
                r_addr  <= r_addr + 1'b1;
                r_state <= S_ISSUE;
              end else begin
                r_out_valid <= 1'b1;
                r_state     <= S_OUT;
              end
            end
          end
          S_OUT: begin
            if (bus.out_ready) begin
              r_out_valid <= 1'b0;
              if (r_row == r_last) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_row   <= r_row + 1'b1;
                r_bit   <= '0;
                r_addr  <= r_addr + 1'b1;
                r_state <= S_ISSUE;
              end
            end
          end
          S_DONE: r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Gated live so a stall or abort can never leak a read onto the decoder.
  assign bus.read_en     = (r_state == S_ISSUE) && !bus.compute_busy && !bus.rd_abort;
  assign bus.READ_ADDR   = r_addr;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_row     = r_row;
  assign bus.out_weights = r_buf;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_weight_readback_sequencer.sv
// Directed bench for weight_readback_sequencer with an array model driving
// COL_BITS from the issued address and a scoreboard of expected reads and beats.
module tb_weight_readback_sequencer;
  localparam int N_R = 81;
  localparam int FXP = 6;
  localparam int N_C = 32;
  localparam int LAT = 2;
  localparam int WW  = N_C * FXP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  weight_readback_sequencer_if #(.N_R(N_R), .FXP(FXP), .N_C(N_C)) bus ();

  weight_readback_sequencer #(.N_R(N_R), .FXP(FXP), .N_C(N_C), .READ_LAT(LAT)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  int            exp_addr[$];
  int            exp_row[$];
  logic [WW-1:0] exp_w[$];

  int cyc = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, beat_cnt = 0;
  int last_pulse = -100;
  int pulse_cyc [512];
  logic [WW-1:0] last_w   = '0;
  logic [WW-1:0] held_w   = '0;
  int            held_row = 0;
  logic          pend     = 1'b0;
  logic          d_re   [LAT] = '{default: 1'b0};
  int            d_addr [LAT] = '{default: 0};

  function automatic logic [31:0] pattern(int a);
    logic [7:0] b;
    b = a[7:0];
    return {b, ~b, b ^ 8'hA5, b + 8'd1};
  endfunction

  // Column c of a row is bit-plane b of that row's read at address row*FXP+b.
  function automatic logic [WW-1:0] model_w(int row);
    logic [WW-1:0] w;
    logic [31:0]   p;
    w = '0;
    for (int b = 0; b < FXP; b++) begin
      p = pattern(row * FXP + b);
      for (int c = 0; c < N_C; c++) w[c*FXP + b] = p[c];
    end
    return w;
  endfunction

  task automatic chk(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    cyc++;
    bus.COL_BITS = d_re[LAT-1] ? pattern(d_addr[LAT-1]) : $urandom();
    for (int i = LAT - 1; i > 0; i--) begin
      d_re[i]   = d_re[i-1];
      d_addr[i] = d_addr[i-1];
    end
    d_re[0]   = bus.read_en;
    d_addr[0] = int'(bus.READ_ADDR);

    if (bus.read_en) begin
      rd_cnt++;
      pulse_cyc[bus.READ_ADDR] = cyc;
      chk("read_en_while_compute_busy", bus.compute_busy, 0);
      chk("read_en_while_out_valid", bus.out_valid, 0);
      chk("read_spacing_ok", (cyc - last_pulse) >= (LAT + 1), 1);
      last_pulse = cyc;
      chk("read_expected", exp_addr.size() > 0, 1);
      if (exp_addr.size() > 0) chk("READ_ADDR", bus.READ_ADDR, exp_addr.pop_front());
    end

    if (bus.out_valid) begin
      if (!pend) begin
        chk("beat_expected", exp_row.size() > 0, 1);
        if (exp_row.size() > 0) begin
          held_row = exp_row.pop_front();
          held_w   = exp_w.pop_front();
        end
      end
      chk("out_row", bus.out_row, held_row);
      chk("out_weights", bus.out_weights, held_w);
      last_w = bus.out_weights;
      if (bus.out_ready) begin
        pend = 1'b0;
        beat_cnt++;
      end else begin
        pend = 1'b1;
      end
    end else begin
      pend = 1'b0;
    end

    if (bus.done) done_cnt++;
    if (bus.err)  err_cnt++;
  end

  task automatic clear_model();
    exp_addr.delete();
    exp_row.delete();
    exp_w.delete();
  endtask

  task automatic start_seq(int f, int l);
    @(posedge clk); #1;
    bus.rd_row_first = f[6:0];
    bus.rd_row_last  = l[6:0];
    bus.rd_start     = 1'b1;
    if (f <= l && l < N_R) begin
      for (int r = f; r <= l; r++) begin
        for (int b = 0; b < FXP; b++) exp_addr.push_back(r * FXP + b);
        exp_row.push_back(r);
        exp_w.push_back(model_w(r));
      end
    end
    @(posedge clk); #1;
    bus.rd_start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < budget);
    chk("sequence_finished", bus.busy, 0);
    chk("model_drained", exp_addr.size() + exp_row.size(), 0);
  endtask

  task automatic wait_valid(int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < budget);
    chk("out_valid_reached", bus.out_valid, 1);
  endtask

  task automatic wait_pulse(int addr, int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.read_en && int'(bus.READ_ADDR) == addr) && n < budget);
    chk("pulse_reached", bus.read_en && int'(bus.READ_ADDR) == addr, 1);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_read_en"}, bus.read_en, 0);
    chk({tag, "_READ_ADDR"}, bus.READ_ADDR, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_row"}, bus.out_row, 0);
    chk({tag, "_out_weights"}, bus.out_weights, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"}, bus.err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, e0, r0, b0;
    bus.rd_start     = 1'b0;
    bus.rd_abort     = 1'b0;
    bus.rd_row_first = '0;
    bus.rd_row_last  = '0;
    bus.compute_busy = 1'b0;
    bus.out_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Single row 5: addresses 30..35 three cycles apart.
    d0 = done_cnt; e0 = err_cnt; r0 = rd_cnt; b0 = beat_cnt;
    start_seq(5, 5);
    wait_idle(200);
    chk("row5_reads", rd_cnt - r0, 6);
    chk("row5_beats", beat_cnt - b0, 1);
    chk("row5_done", done_cnt - d0, 1);
    chk("row5_err", err_cnt - e0, 0);
    chk("row5_pulse_span", pulse_cyc[35] - pulse_cyc[30], 15);
    chk("row5_col0_weight", last_w[0 +: FXP], 21);
    chk("row5_col24_weight", last_w[24*FXP +: FXP], 42);

    // Last two rows reach the top address 485.
    d0 = done_cnt; r0 = rd_cnt; b0 = beat_cnt;
    start_seq(79, 80);
    wait_idle(300);
    chk("top_reads", rd_cnt - r0, 12);
    chk("top_beats", beat_cnt - b0, 2);
    chk("top_done", done_cnt - d0, 1);
    chk("top_pulse_span", pulse_cyc[485] - pulse_cyc[474], 34);

    // Invalid ranges: done and err the cycle after the start pulse.
    d0 = done_cnt; e0 = err_cnt; r0 = rd_cnt;
    start_seq(3, 2);
    chk("inv_order_done", bus.done, 1);
    chk("inv_order_err", bus.err, 1);
    chk("inv_order_busy", bus.busy, 0);
    start_seq(0, 81);
    chk("inv_range_err", bus.err, 1);
    repeat (5) @(negedge clk);
    chk("inv_reads", rd_cnt - r0, 0);
    chk("inv_done_count", done_cnt - d0, 2);
    chk("inv_err_count", err_cnt - e0, 2);

    // Back-pressure during OUT.
    @(posedge clk); #1 bus.out_ready = 1'b0;
    r0 = rd_cnt; b0 = beat_cnt;
    start_seq(10, 11);
    wait_valid(100);
    d0 = rd_cnt;
    repeat (10) @(negedge clk);
    chk("bp_no_reads", rd_cnt - d0, 0);
    chk("bp_valid_held", bus.out_valid, 1);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_idle(300);
    chk("bp_reads", rd_cnt - r0, 12);
    chk("bp_beats", beat_cnt - b0, 2);

    // compute_busy stall while issuing address 32.
    d0 = done_cnt;
    start_seq(5, 5);
    wait_pulse(31, 100);
    repeat (3) @(posedge clk);
    #1 bus.compute_busy = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.compute_busy = 1'b0;
    wait_idle(200);
    chk("stall_gap", pulse_cyc[32] - pulse_cyc[31], 8);
    chk("stall_done", done_cnt - d0, 1);
    chk("stall_col0_weight", last_w[0 +: FXP], 21);

    // Abort while waiting on a read, then a clean restart.
    start_seq(20, 21);
    wait_pulse(122, 100);
    @(posedge clk); #1 bus.rd_abort = 1'b1;
    clear_model();
    @(posedge clk); #1 bus.rd_abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_read_en", bus.read_en, 0);
    d0 = done_cnt; r0 = rd_cnt; b0 = beat_cnt;
    repeat (20) @(negedge clk);
    chk("abort_no_reads", rd_cnt - r0, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_beats", beat_cnt - b0, 0);
    start_seq(20, 20);
    wait_idle(200);
    chk("restart_done", done_cnt - d0, 1);
    chk("restart_beats", beat_cnt - b0, 1);

    // Asynchronous reset in the middle of a multi-row read.
    start_seq(40, 42);
    wait_valid(100);
    @(posedge clk); #3 rst_n = 1'b0;
    clear_model();
    #1 chk_all_zero("midreset");
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", bus.busy, 0);
    d0 = done_cnt; b0 = beat_cnt;
    start_seq(2, 2);
    wait_idle(200);
    chk("post_reset_done", done_cnt - d0, 1);
    chk("post_reset_beats", beat_cnt - b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
